// File: rtl/camera_capture_ctrl.sv
// Camera front-end: turns the href/vsync byte stream into cropped, coordinate-tagged pixels
// and hands them out through a small FIFO, with debounced shutter-driven capture modes.
module camera_capture_ctrl #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned BPP             = 2,
  parameter int unsigned COLS            = 640,
  parameter int unsigned ROWS            = 480,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cam_href,
  input  logic                      cam_vsync,
  input  logic [DATA_W-1:0]         cam_data,
  input  logic                      shutter_in,
  input  logic                      mode_continuous,
  output logic [BPP*DATA_W-1:0]     pix_data,
  output logic [$clog2(COLS)-1:0]   pix_x,
  output logic [$clog2(ROWS)-1:0]   pix_y,
  output logic                      pix_sof,
  output logic                      pix_eol,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      frame_done,
  output logic                      overflow,
  output logic                      busy
);

  localparam int unsigned PW   = BPP * DATA_W;
  localparam int unsigned SRW  = (BPP > 1) ? (BPP - 1) * DATA_W : DATA_W;
  localparam int unsigned XW   = $clog2(COLS);
  localparam int unsigned YW   = $clog2(ROWS);
  localparam int unsigned XCW  = $clog2(COLS + 1);
  localparam int unsigned YCW  = $clog2(ROWS + 1);
  localparam int unsigned BCW  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int unsigned DCW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW   = PW + XW + YW + 2;

  localparam logic [XCW-1:0]  ColsC    = XCW'(COLS);
  localparam logic [XCW-1:0]  LastColC = XCW'(COLS - 1);
  localparam logic [YCW-1:0]  RowsC    = YCW'(ROWS);
  localparam logic [BCW-1:0]  LastByteC = BCW'(BPP - 1);
  localparam logic [DCW-1:0]  DebLastC = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNTW-1:0] DepthC   = CNTW'(FIFO_DEPTH);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StSync      = 2'd1;
  localparam logic [1:0] StWaitStart = 2'd2;
  localparam logic [1:0] StCapture   = 2'd3;

  logic            sh_meta_q, sh_sync_q;
  logic            deb_q, deb_d;
  logic [DCW-1:0]  deb_cnt_q, deb_cnt_d;
  logic            arm_q, arm_d;

  logic [1:0]      state_q, state_d;
  logic            cont_q, cont_d;
  logic            stop_q, stop_d;
  logic            fd_q, fd_d;
  logic            ovf_q, ovf_d;
  logic            vsync_prev_q, href_prev_q;

  logic [SRW-1:0]  pix_sr_q, pix_sr_d;
  logic [PW-1:0]   pix_shift;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [XCW-1:0]  x_q, x_d;
  logic [YCW-1:0]  y_q, y_d;

  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic vs_rise, vs_fall, href_fall, start_frame, ovf_clr;
  logic push_req, push, pop, full, drop;
  logic [EW-1:0] entry;

  assign vs_rise = cam_vsync & ~vsync_prev_q;
  assign vs_fall = ~cam_vsync & vsync_prev_q;

  // Shutter debounce: the filtered level flips only after a full run of differing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sh_sync_q != deb_q) begin
      if (deb_cnt_q == DebLastC) begin
        deb_d = sh_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    arm_d = deb_d & ~deb_q;
  end

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    stop_d      = stop_q;
    fd_d        = 1'b0;
    ovf_clr     = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      StIdle: begin
        if (arm_q) begin
          state_d = StSync;
          cont_d  = mode_continuous;
          stop_d  = 1'b0;
          ovf_clr = 1'b1;
        end
      end
      StSync: begin
        if (cam_vsync) state_d = StWaitStart;
      end
      StWaitStart: begin
        if (vs_fall) begin
          state_d     = StCapture;
          start_frame = 1'b1;
        end
      end
      StCapture: begin
        if (vs_rise) begin
          fd_d    = 1'b1;
          state_d = (cont_q && !stop_q && !arm_q) ? StWaitStart : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A fresh press during a continuous run ends it at the next frame boundary.
    if (state_q != StIdle && arm_q && cont_q) stop_d = 1'b1;
  end

  generate
    if (BPP > 1) begin : g_multi_byte
      assign pix_shift = {pix_sr_q, cam_data};
    end else begin : g_single_byte
      assign pix_shift = cam_data;
    end
  endgenerate

  assign href_fall = (state_q == StCapture) && href_prev_q && !cam_href;

  always_comb begin
    pix_sr_d   = pix_sr_q;
    byte_cnt_d = byte_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    push_req   = 1'b0;
    if (start_frame) begin
      byte_cnt_d = '0;
      x_d        = '0;
      y_d        = '0;
    end else if (state_q == StCapture && cam_href) begin
      pix_sr_d = pix_shift[SRW-1:0];
      if (byte_cnt_q == LastByteC) begin
        byte_cnt_d = '0;
        push_req   = (x_q < ColsC) && (y_q < RowsC);
        if (x_q < ColsC) x_d = x_q + 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else if (href_fall) begin
      // Any partial pixel left at line end is discarded.
      byte_cnt_d = '0;
      x_d        = '0;
      if (x_q != '0 && y_q < RowsC) y_d = y_q + 1'b1;
    end
  end

  assign entry = {pix_shift, x_q[XW-1:0], y_q[YW-1:0],
                  (x_q == '0) && (y_q == '0), (x_q == LastColC)};

  assign full = (cnt_q == DepthC);
  assign pop  = pix_valid && pix_ready;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
    ovf_d = ovf_clr ? 1'b0 : (ovf_q | drop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_meta_q    <= 1'b0;
      sh_sync_q    <= 1'b0;
      deb_q        <= 1'b0;
      deb_cnt_q    <= '0;
      arm_q        <= 1'b0;
      state_q      <= StIdle;
      cont_q       <= 1'b0;
      stop_q       <= 1'b0;
      fd_q         <= 1'b0;
      ovf_q        <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      pix_sr_q     <= '0;
      byte_cnt_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      sh_meta_q    <= shutter_in;
      sh_sync_q    <= sh_meta_q;
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
      arm_q        <= arm_d;
      state_q      <= state_d;
      cont_q       <= cont_d;
      stop_q       <= stop_d;
      fd_q         <= fd_d;
      ovf_q        <= ovf_d;
      vsync_prev_q <= cam_vsync;
      href_prev_q  <= cam_href;
      pix_sr_q     <= pix_sr_d;
      byte_cnt_q   <= byte_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Head entry is masked while empty so idle outputs read as zero.
  always_comb begin
    pix_valid = (cnt_q != '0);
    {pix_data, pix_x, pix_y, pix_sof, pix_eol} = pix_valid ? mem_q[rd_ptr_q] : '0;
  end

  assign frame_done = fd_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/camera_capture_ctrl.md
Name: camera_capture_ctrl

Overview:
- Parametrised camera front-end. Converts the raw camera byte stream (href/vsync/8-bit data) into whole pixels with coordinates and frame markers.
- Crops each frame to a COLS x ROWS window.
- Adds shutter-driven capture modes: single-shot or continuous.
- Buffers pixels in a small FIFO and hands them to the downstream frame writer over a valid/ready handshake.

Parameters:
- DATA_W, 8, camera byte width.
- BPP, 2, bytes per pixel, legal 1..4; 2 = RGB565.
- COLS, 640, pixels kept per line; later pixels are dropped.
- ROWS, 480, lines kept per frame; later lines are dropped.
- FIFO_DEPTH, 8, output FIFO entries, power of two, at least 2.
- DEBOUNCE_CYCLES, 250000, cycles shutter must be stable (10 ms at 25 MHz).

Ports:
- clk  in  1  25 MHz clock; camera inputs are synchronous to it.
- reset_n  in  1  asynchronous active-low reset.
- cam_href  in  1  line-valid.
- cam_vsync  in  1  frame-sync pulse, high between frames.
- cam_data  in  DATA_W  camera byte.
- shutter_in  in  1  raw switch, asynchronous.
- mode_continuous  in  1  1 = capture every frame, 0 = single-shot per shutter press; sampled only in IDLE.
- pix_data  out  BPP*DATA_W  pixel, first byte in MSBs.
- pix_x  out  $clog2(COLS)  column.
- pix_y  out  $clog2(ROWS)  row.
- pix_sof  out  1  pixel (0,0).
- pix_eol  out  1  pix_x == COLS-1.
- pix_valid  out  1  output holds a pixel.
- pix_ready  in  1  consumer accepts.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: async on reset_n low. All outputs 0, FIFO empty, counters 0, state IDLE, debounced shutter 0.
- Shutter path:
  - 2-flop synchroniser, then debounce counter; output changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A rising edge of the debounced signal produces a one-cycle arm pulse.
- States:
  - IDLE: on arm go to SYNC; latch mode_continuous; clear overflow.
  - SYNC: wait for cam_vsync high, then go to WAIT_START. Never begin mid-frame.
  - WAIT_START: wait for cam_vsync falling (registered previous value 1, current 0); clear x, y and byte count; go to CAPTURE.
  - CAPTURE: on cam_vsync rising, pulse frame_done on the next cycle. If continuous, go to WAIT_START; else go to IDLE.
  - While not IDLE, arm pulses are ignored.
  - In continuous mode, an arm pulse from a new press stops capture at the next frame end: go to IDLE instead of WAIT_START.
- Byte assembly (CAPTURE only, cam_href high):
  - Shift cam_data into the pixel register; byte_cnt runs 0..BPP-1.
  - At byte_cnt == BPP-1 the pixel is complete; byte_cnt wraps to 0.
  - cam_href falling with byte_cnt != 0 discards the partial pixel; byte_cnt = 0.
- Coordinates:
  - x increments per completed pixel and saturates at COLS. y increments on cam_href falling when x > 0, saturating at ROWS. x clears on cam_href falling.
  - A completed pixel is pushed only if x < COLS and y < ROWS.
  - pix_sof = (x==0 && y==0); pix_eol = (x==COLS-1). Both are stored with the pixel in the FIFO.
- FIFO:
  - Push latency: pixel visible at the output 1 cycle after its last byte is sampled, if the FIFO was empty.
  - Pop when pix_valid && pix_ready.
  - Full FIFO with a simultaneous pop still accepts the push.
  - Full FIFO without a pop drops the pixel (counters still advance) and sets overflow.
- Output hold: while pix_valid && !pix_ready, the outputs hold stable.
- frame_done ordering: it follows the last push. Pixels already in the FIFO keep draining after frame_done and in IDLE.
- Simultaneous events: cam_vsync rising in the same cycle as the last byte still completes and pushes that pixel.
- Reset mid-frame: everything cleared, FIFO contents lost; resumes at IDLE.

Test Plan:
- Single-shot: shutter held 1 for DEBOUNCE_CYCLES (set 4 in bench), frame COLS=4 ROWS=2 BPP=2, bytes A0,B1,... -> 8 pixels, first 16'hA0B1 with sof=1, eol on x=3, frame_done once, busy returns 0.
- Crop: 6-pixel lines x 3 rows into COLS=4 ROWS=2 -> exactly 8 pixels, x never exceeds 3, y never exceeds 1.
- Partial pixel: href drops after 1 byte of pixel 2 -> partial discarded; next line starts x=0 with a correct 2-byte pixel.
- Backpressure: pix_ready=0 for a whole line of 12 pixels, FIFO_DEPTH=8 -> 8 stored, overflow=1; stored pixels drain in order once ready=1.
- Continuous: mode_continuous=1, 3 frames -> 3 frame_done pulses, sof at each frame start; second shutter press mid-frame 2 -> IDLE after frame 2 ends.
- Async reset asserted mid-line -> all outputs 0 immediately, no pixels until the next arm and vsync.
